// File: rtl/app_mult_pkg.sv
// Shared types and constants for the app_mult_approx approximate multiplier.
package app_mult_pkg;
    localparam int WIDTH_C = 16;
    localparam int KEEP_C  = 8;
    localparam int SHW     = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        NORM = 3'd2,
        MULT = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/app_mult_lod_shift.sv
// Per-operand normalizer: shifts left until the MSB is set, counting shifts, and
// presents the top KEEP bits (rounded half up when APP_MULT_ROUND_EN is defined).
module app_mult_lod_shift
    import app_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int KEEP  = KEEP_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb,
    output logic             zero,
    output logic [SHW-1:0]   cnt,
    output logic [KEEP-1:0]  mant
);
    logic [WIDTH-1:0] r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            cnt <= '0;
        end else if (load) begin
            r   <= d;
            cnt <= '0;
        end else if (shift && !r[WIDTH-1]) begin
            r   <= r << 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign msb  = r[WIDTH-1];
    assign zero = (r == '0);

`ifdef APP_MULT_ROUND_EN
    logic [KEEP:0] rnd;
    assign rnd  = {1'b0, r[WIDTH-1 -: KEEP]} + {{KEEP{1'b0}}, r[WIDTH-KEEP-1]};
    // A carry out of the kept bits means the mantissa was all ones: saturate.
    assign mant = rnd[KEEP] ? {KEEP{1'b1}} : rnd[KEEP-1:0];
`else
    assign mant = r[WIDTH-1 -: KEEP];
`endif
endmodule

// File: rtl/app_mult_approx.sv
// Sequential approximate 16x16 multiplier: normalize, truncate to 8-bit mantissas,
// shift-add multiply, realign to product bits [31:16]. Option: APP_MULT_ROUND_EN.
module app_mult_approx
    import app_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int KEEP  = KEEP_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [2:0]       state_dbg
);
    localparam int CW = $clog2(KEEP);
    localparam logic [SHW:0] LIM = (SHW+1)'(WIDTH);

    state_t state, state_nxt;

    logic            a_msb, b_msb, a_zero, b_zero;
    logic [SHW-1:0]  sa, sb;
    logic [KEEP-1:0] a_m, b_m, a8, b8;
    logic [CW-1:0]   bit_cnt;
    logic [WIDTH-1:0] p, addend, p_nxt, realign;
    logic [SHW:0]    shamt;
    logic            load_op, both_norm, last_bit;

    assign load_op   = (state == IDLE) && start;
    assign both_norm = a_msb && b_msb;
    assign last_bit  = (bit_cnt == CW'(KEEP-1));

    app_mult_lod_shift #(.WIDTH(WIDTH), .KEEP(KEEP)) u_lod_a (
        .clk(clk), .rst(rst), .load(load_op), .shift(state == NORM), .d(A),
        .msb(a_msb), .zero(a_zero), .cnt(sa), .mant(a_m)
    );

    app_mult_lod_shift #(.WIDTH(WIDTH), .KEEP(KEEP)) u_lod_b (
        .clk(clk), .rst(rst), .load(load_op), .shift(state == NORM), .d(B),
        .msb(b_msb), .zero(b_zero), .cnt(sb), .mant(b_m)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (a_zero || b_zero) ? DONE : NORM;
            NORM: if (both_norm) state_nxt = MULT;
            MULT: if (last_bit) state_nxt = DONE;
            DONE: if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add step and the final realign are combinational on the current partial sum.
    always_comb begin
        addend  = b8[bit_cnt] ? ({{(WIDTH-KEEP){1'b0}}, a8} << bit_cnt) : '0;
        p_nxt   = p + addend;
        shamt   = {1'b0, sa} + {1'b0, sb};
        realign = (shamt >= LIM) ? '0 : (p_nxt >> shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a8      <= '0;
            b8      <= '0;
            bit_cnt <= '0;
            p       <= '0;
            Result  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    p       <= '0;
                    bit_cnt <= '0;
                end
                LOAD: if (a_zero || b_zero) Result <= '0;
                NORM: if (both_norm) begin
                    a8      <= a_m;
                    b8      <= b_m;
                    bit_cnt <= '0;
                end
                MULT: begin
                    p       <= p_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) Result <= realign;
                end
                default: ;
            endcase
        end
    end

    assign Done      = (state == DONE);
    assign state_dbg = state;
endmodule

// File: tb/tb_app_mult_approx.sv
// Self-checking bench for app_mult_approx: directed plan cases, reset abort, and
// random operands scored against an independent leading-zero model.
module tb_app_mult_approx;
    import app_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        done;
    logic [15:0] result;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    app_mult_approx dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .Done(done), .Result(result), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lead_zeros(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] mant_of(input logic [15:0] v);
        logic [15:0] nv;
        logic [8:0]  rnd;
        nv  = v << lead_zeros(v);
        rnd = {1'b0, nv[15:8]};
`ifdef APP_MULT_ROUND_EN
        rnd = rnd + nv[7];
        if (rnd > 9'd255) rnd = 9'd255;
`endif
        return rnd[7:0];
    endfunction

    function automatic logic [15:0] model(input logic [15:0] xa, input logic [15:0] xb);
        int unsigned prod;
        int sh;
        if (xa == 0 || xb == 0) return 16'h0;
        prod = mant_of(xa) * mant_of(xb);
        sh   = lead_zeros(xa) + lead_zeros(xb);
        if (sh >= 16) return 16'h0;
        return 16'(prod >> sh);
    endfunction

    function automatic int latency(input logic [15:0] xa, input logic [15:0] xb);
        int za, zb;
        if (xa == 0 || xb == 0) return 2;
        za = lead_zeros(xa);
        zb = lead_zeros(xb);
        return 2 + ((za > zb) ? za : zb) + 1 + 8;
    endfunction

    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input int hold);
        int cycles;
        int exp_lat;
        logic [15:0] expv;
        exp_q.push_back(model(xa, xb));
        exp_lat = latency(xa, xb);
        a = xa;
        b = xb;
        start = 1'b1;
        cycles = 0;
        do begin
            step();
            cycles++;
            // Operands changing after capture must not disturb the operation.
            if (cycles == 1) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end while (!done && cycles < 200);
        check("done_seen", done, 1);
        check("latency", cycles, exp_lat);
        expv = exp_q.pop_front();
        check("result", result, expv);
        repeat (hold) step();
        check("done_hold", done, 1);
        start = 1'b0;
        step();
        check("done_drop", done, 0);
        check("idle_after", state_dbg, IDLE);
        check("result_kept", result, expv);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (2) step();
        rst = 1'b0;
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_state", state_dbg, IDLE);

        run_op(16'h2000, 16'h0040, 5);
        run_op(16'h0100, 16'h0100, 1);
        run_op(16'hFFFF, 16'hFFFF, 0);
        check("ffff_const", result, 16'hFE01);
        run_op(16'h0000, 16'h1234, 0);
        run_op(16'h0003, 16'h0005, 0);

        run_op(16'hFFFF, 16'hFFFF, 0);
        a = 16'h2000;
        b = 16'h0040;
        start = 1'b1;
        repeat (14) step();
        check("in_mult", state_dbg, MULT);
        rst = 1'b1;
        step();
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_state", state_dbg, IDLE);
        rst = 1'b0;
        start = 1'b0;
        step();
        run_op(16'h0100, 16'h0100, 0);
        check("recover_const", result, 16'h0001);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            run_op(ra, rb, $urandom_range(0, 2));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
